kbd_text_writer: RTL

- Sits between ps2_keyboard and VGA_Pattern.
- Consumes ASCII bytes from the keyboard receiver through the rx_data_ready/rx_read handshake.
- Holds a COLS x ROWS character buffer in on-chip RAM and owns the text cursor: placement, line wrap, Enter, backspace and clear-screen.
- Gives the VGA stage a registered read port plus cursor pixel coordinates (replaces the ad-hoc col_no/row_no logic at top level).

---
 rtl/kbd_text_pkg.sv | 13 +
 rtl/kbd_text_ram.sv | 23 ++
 rtl/kbd_text_writer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/kbd_text_pkg.sv
// kbd_text_pkg: shared FSM encoding, ASCII constants and helpers for kbd_text_writer.
package kbd_text_pkg;
  typedef enum logic [1:0] {CLEAR, IDLE, EXEC} state_t;
  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_ESC      = 8'h1B;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;
  function automatic logic is_print(input logic [7:0] c);
    return c >= CH_PRINT_LO && c <= CH_PRINT_HI;
  endfunction
endpackage

// File: rtl/kbd_text_ram.sv
// kbd_text_ram: simple dual-port character RAM, one write port, registered read-before-write read port.
//   clk, rst_n     clock, async active-low reset (read register only)
//   we/waddr/wdata write port
//   raddr/rdata    read port, rdata valid one cycle after raddr
module kbd_text_ram #(
  parameter int DEPTH = 192,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else rdata <= mem[raddr];
endmodule

// File: rtl/kbd_text_writer.sv
// kbd_text_writer: keyboard-to-screen text buffer with cursor, wrap, Enter, backspace and clear.
//   iCLK, iRST_N               clock, async active-low reset
//   iAscii/iAscii_valid        byte from ps2_keyboard; oAscii_read acknowledges it for one cycle
//   iRd_col/iRd_row/oRd_char   VGA read port, one-cycle latency, out-of-range reads give a space
//   oCur_col/row/x/y, oCur_vis cursor cell, pixel position and visibility
//   oBusy                      clear sweep in progress
//   KBD_TEXT_WRITER_BLINK_EN   when defined, oCur_vis blinks every BLINK_CYCLES cycles
module kbd_text_writer
  import kbd_text_pkg::*;
#(
  parameter int COLS         = 16,
  parameter int ROWS         = 12,
  parameter int COL_W        = 4,
  parameter int ROW_W        = 4,
  parameter int CELL_PX      = 40,
  parameter int BLINK_CYCLES = 13500000
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [7:0]       iAscii,
  input  logic             iAscii_valid,
  output logic             oAscii_read,
  input  logic [COL_W-1:0] iRd_col,
  input  logic [ROW_W-1:0] iRd_row,
  output logic [7:0]       oRd_char,
  output logic [COL_W-1:0] oCur_col,
  output logic [ROW_W-1:0] oCur_row,
  output logic [9:0]       oCur_x,
  output logic [9:0]       oCur_y,
  output logic             oCur_vis,
  output logic             oBusy
);
  localparam int AW = COL_W + ROW_W;
  localparam int DEPTH = COLS * ROWS;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  if (COLS > 2**COL_W || ROWS > 2**ROW_W || BLINK_CYCLES < 1) begin : g_bad_params
    $error("kbd_text_writer: invalid parameters");
  end
  function automatic logic [AW-1:0] addr_of(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction
  state_t state, state_n;
  logic [AW-1:0] sweep, sweep_n, waddr, raddr;
  logic [COL_W-1:0] col, col_n, bs_col;
  logic [ROW_W-1:0] row, row_n, bs_row, inc_row;
  logic [7:0] ch, ch_n, wdata, ram_q;
  logic ack, ack_n, we, oor, oor_q;
  assign inc_row = row == ROW_MAX ? '0 : row + 1'b1;
  // Backspace steps back one cell, wrapping to the previous row's last column; (0,0) stays put.
  assign bs_col = col != '0 ? col - 1'b1 : row != '0 ? COL_MAX : col;
  assign bs_row = col == '0 && row != '0 ? row - 1'b1 : row;
  always_comb begin
    state_n = state;
    sweep_n = sweep;
    col_n = col;
    row_n = row;
    ch_n = ch;
    ack_n = 1'b0;
    we = 1'b0;
    waddr = addr_of(row, col);
    wdata = CH_SPACE;
    case (state)
      CLEAR: begin
        we = 1'b1;
        waddr = sweep;
        sweep_n = sweep + 1'b1;
        state_n = sweep == LAST ? IDLE : CLEAR;
      end
      IDLE: if (iAscii_valid && !ack) begin
        ch_n = iAscii;
        ack_n = 1'b1;
        state_n = EXEC;
      end
      EXEC: begin
        state_n = IDLE;
        if (is_print(ch)) begin
          we = 1'b1;
          wdata = ch;
          col_n = col == COL_MAX ? '0 : col + 1'b1;
          row_n = col == COL_MAX ? inc_row : row;
        end else if (ch == CH_CR) begin
          col_n = '0;
          row_n = inc_row;
        end else if (ch == CH_BS) begin
          we = 1'b1;
          col_n = bs_col;
          row_n = bs_row;
          waddr = addr_of(bs_row, bs_col);
        end else if (ch == CH_ESC) begin
          col_n = '0;
          row_n = '0;
          sweep_n = '0;
          state_n = CLEAR;
        end
      end
      default: state_n = CLEAR;
    endcase
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      state <= CLEAR;
      sweep <= '0;
      col <= '0;
      row <= '0;
      oCur_x <= '0;
      oCur_y <= '0;
      ch <= '0;
      ack <= 1'b0;
      oor_q <= 1'b0;
    end else begin
      state <= state_n;
      sweep <= sweep_n;
      col <= col_n;
      row <= row_n;
      oCur_x <= 10'(col_n) * 10'(CELL_PX);
      oCur_y <= 10'(row_n) * 10'(CELL_PX);
      ch <= ch_n;
      ack <= ack_n;
      oor_q <= oor;
    end
  // Out-of-range reads are steered to a legal address and masked to a space on the way out.
  assign oor = iRd_col > COL_MAX || iRd_row > ROW_MAX;
  assign raddr = oor ? '0 : addr_of(iRd_row, iRd_col);
  assign oRd_char = oor_q ? CH_SPACE : ram_q;
  assign oAscii_read = ack;
  assign oCur_col = col;
  assign oCur_row = row;
  assign oBusy = state == CLEAR;
  kbd_text_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(iCLK),
    .rst_n(iRST_N),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(ram_q)
  );
`ifdef KBD_TEXT_WRITER_BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  logic [BW-1:0] blink_cnt;
  logic vis, moved;
  // Any cursor move restarts the blink phase so the cursor shows right after typing.
  assign moved = col_n != col || row_n != row;
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      blink_cnt <= '0;
      vis <= 1'b1;
    end else if (moved) begin
      blink_cnt <= '0;
      vis <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      vis <= ~vis;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  assign oCur_vis = vis;
`else
  assign oCur_vis = 1'b1;
`endif
endmodule
